branch_fwd_unit_nlane: RTL and testbench

- Parametrised successor of the MEM-stage branch operand forwarding logic for the multi-issue in-order pipeline.
- For every lane whose MEM-stage instruction is a branch, selects and delivers the forwarded rs/rt data. Sources:
  - older lanes of the same MEM packet;
  - all WB lanes;
  - a short history of retired writebacks.
- Replaces the fixed two-lane select codes with a lane-count-generic datapath.
- Adds a one-cycle load-use stall with a capture latch for same-packet load producers.

---
 rtl/branch_fwd_pkg.sv | 18 +
 rtl/branch_fwd_match.sv | 97 +++++++++
 rtl/branch_fwd_unit_nlane.sv | 193 +++++++++++++++++++
 tb/tb_branch_fwd_unit_nlane.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_fwd_pkg.sv
// Shared types and limits for the N-lane MEM-stage branch operand forwarding unit.
package branch_fwd_pkg;

  localparam int LANES_MAX  = 4;
  localparam int HIST_MAX   = 4;
  localparam int LANE_IDX_W = $clog2(LANES_MAX);

  typedef enum logic {IDLE, HOLD} fsm_state_e;

  typedef enum logic [2:0] {
    SRC_RF,
    SRC_LATCH,
    SRC_MEM,
    SRC_WB,
    SRC_HIST
  } src_sel_e;

endpackage

// File: rtl/branch_fwd_match.sv
// Priority matcher for one branch source operand: hold latch, older MEM lanes,
// WB lanes, then retired-writeback history. Reports a load-use hazard instead of forwarding.
module branch_fwd_match
  import branch_fwd_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int HD     = 2,
  parameter int LANE   = 0
) (
  input  logic [REG_W-1:0]                      src,
  input  logic                                  latch_on,
  input  logic [DATA_W-1:0]                     latch_data,
  input  logic [LANES-1:0]                      mem_wr,
  input  logic [LANES-1:0]                      mem_load,
  input  logic [LANES-1:0][REG_W-1:0]           mem_dest,
  input  logic [LANES-1:0][DATA_W-1:0]          mem_alu,
  input  logic [LANES-1:0][DATA_W-1:0]          mem_rdata,
  input  logic [LANES-1:0]                      wb_wr,
  input  logic [LANES-1:0][REG_W-1:0]           wb_dest,
  input  logic [LANES-1:0][DATA_W-1:0]          wb_data,
  input  logic [HD-1:0][LANES-1:0]              hist_wr,
  input  logic [HD-1:0][LANES-1:0][REG_W-1:0]   hist_dest,
  input  logic [HD-1:0][LANES-1:0][DATA_W-1:0]  hist_data,
  output src_sel_e                              sel,
  output logic [DATA_W-1:0]                     data,
  output logic                                  hazard,
  output logic [DATA_W-1:0]                     hazard_data
);

  logic              src_nz;
  logic              mem_hit, mem_ld, wb_hit, h_hit;
  logic [DATA_W-1:0] mem_d, mem_rd, wb_d, h_d;

  assign src_nz = (src != '0);

  // Ascending scans so the last hit (youngest producer) is what remains.
  always_comb begin
    mem_hit = 1'b0;
    mem_ld  = 1'b0;
    mem_d   = '0;
    mem_rd  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < LANE && mem_wr[j] && mem_dest[j] == src) begin
        mem_hit = 1'b1;
        mem_ld  = mem_load[j];
        mem_d   = mem_alu[j];
        mem_rd  = mem_rdata[j];
      end
    end
    wb_hit = 1'b0;
    wb_d   = '0;
    for (int j = 0; j < LANES; j++) begin
      if (wb_wr[j] && wb_dest[j] == src) begin
        wb_hit = 1'b1;
        wb_d   = wb_data[j];
      end
    end
    h_hit = 1'b0;
    h_d   = '0;
    for (int p = HD - 1; p >= 0; p--) begin
      for (int l = 0; l < LANES; l++) begin
        if (hist_wr[p][l] && hist_dest[p][l] == src) begin
          h_hit = 1'b1;
          h_d   = hist_data[p][l];
        end
      end
    end
  end

  always_comb begin
    sel         = SRC_RF;
    data        = '0;
    hazard      = 1'b0;
    hazard_data = '0;
    if (latch_on) begin
      sel  = SRC_LATCH;
      data = latch_data;
    end else if (src_nz && mem_hit) begin
      if (mem_ld) begin
        hazard      = 1'b1;
        hazard_data = mem_rd;
      end else begin
        sel  = SRC_MEM;
        data = mem_d;
      end
    end else if (src_nz && wb_hit) begin
      sel  = SRC_WB;
      data = wb_d;
    end else if (src_nz && h_hit) begin
      sel  = SRC_HIST;
      data = h_d;
    end
  end

endmodule

// File: rtl/branch_fwd_unit_nlane.sv
// N-lane MEM-stage branch operand forwarding with one-cycle load-use stall and capture latch.
// Define BRANCH_FWD_HIST_EN to add the retired-writeback history buffer as the lowest-priority source.
module branch_fwd_unit_nlane
  import branch_fwd_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [LANES-1:0]          mem_valid_i,
  input  logic [LANES-1:0]          mem_branch_i,
  input  logic [LANES-1:0]          mem_regwr_i,
  input  logic [LANES-1:0]          mem_load_i,
  input  logic [LANES*REG_W-1:0]    mem_dest_i,
  input  logic [LANES*DATA_W-1:0]   mem_alu_i,
  input  logic [LANES*DATA_W-1:0]   mem_rdata_i,
  input  logic [LANES*REG_W-1:0]    mem_rs_i,
  input  logic [LANES*REG_W-1:0]    mem_rt_i,
  input  logic [LANES-1:0]          wb_valid_i,
  input  logic [LANES-1:0]          wb_regwr_i,
  input  logic [LANES*REG_W-1:0]    wb_dest_i,
  input  logic [LANES*DATA_W-1:0]   wb_data_i,
  output logic [LANES-1:0]          fwd_a_en_o,
  output logic [LANES-1:0]          fwd_b_en_o,
  output logic [LANES*DATA_W-1:0]   fwd_a_data_o,
  output logic [LANES*DATA_W-1:0]   fwd_b_data_o,
  output logic                      stall_o
);

  localparam int HD = (HIST_DEPTH > HIST_MAX) ? HIST_MAX : ((HIST_DEPTH < 1) ? 1 : HIST_DEPTH);

  logic [LANES-1:0][REG_W-1:0]  mem_dest, mem_rs, mem_rt, wb_dest;
  logic [LANES-1:0][DATA_W-1:0] mem_alu, mem_rdata, wb_data, fwd_a_data, fwd_b_data;
  logic [LANES-1:0]             br, mem_wr, wb_wr, haz_a, haz_b;
  logic [LANES-1:0][DATA_W-1:0] hzd_a, hzd_b;

  logic [HD-1:0][LANES-1:0]              hist_wr_reg;
  logic [HD-1:0][LANES-1:0][REG_W-1:0]   hist_dest_reg;
  logic [HD-1:0][LANES-1:0][DATA_W-1:0]  hist_data_reg;

  fsm_state_e              state_reg;
  logic [LANE_IDX_W-1:0]   hold_lane_reg, cap_lane;
  logic                    arm_a_reg, arm_b_reg, latch_ok;
  logic [DATA_W-1:0]       hold_a_reg, hold_b_reg, cap_da, cap_db;
  logic                    hz_any, cap_a, cap_b;

  assign mem_dest     = mem_dest_i;
  assign mem_rs       = mem_rs_i;
  assign mem_rt       = mem_rt_i;
  assign wb_dest      = wb_dest_i;
  assign mem_alu      = mem_alu_i;
  assign mem_rdata    = mem_rdata_i;
  assign wb_data      = wb_data_i;
  assign fwd_a_data_o = fwd_a_data;
  assign fwd_b_data_o = fwd_b_data;

  assign br     = mem_valid_i & mem_branch_i;
  assign mem_wr = mem_valid_i & mem_regwr_i;
  assign wb_wr  = wb_valid_i & wb_regwr_i;

  // A flush or reset in HOLD kills the latched operands in the same cycle.
  assign latch_ok = rst_n && !flush_i && (state_reg == HOLD);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      src_sel_e          sel_a, sel_b;
      logic              hz_a, hz_b, lon_a, lon_b, en_a, en_b;
      logic [DATA_W-1:0] d_a, d_b;

      assign lon_a = latch_ok && arm_a_reg && (hold_lane_reg == LANE_IDX_W'(gi));
      assign lon_b = latch_ok && arm_b_reg && (hold_lane_reg == LANE_IDX_W'(gi));

      branch_fwd_match #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_W(REG_W), .HD(HD), .LANE(gi)
      ) u_match_a (
        .src(mem_rs[gi]), .latch_on(lon_a), .latch_data(hold_a_reg),
        .mem_wr(mem_wr), .mem_load(mem_load_i), .mem_dest(mem_dest),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .wb_wr(wb_wr), .wb_dest(wb_dest), .wb_data(wb_data),
        .hist_wr(hist_wr_reg), .hist_dest(hist_dest_reg), .hist_data(hist_data_reg),
        .sel(sel_a), .data(d_a), .hazard(hz_a), .hazard_data(hzd_a[gi])
      );

      branch_fwd_match #(
        .LANES(LANES), .DATA_W(DATA_W), .REG_W(REG_W), .HD(HD), .LANE(gi)
      ) u_match_b (
        .src(mem_rt[gi]), .latch_on(lon_b), .latch_data(hold_b_reg),
        .mem_wr(mem_wr), .mem_load(mem_load_i), .mem_dest(mem_dest),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .wb_wr(wb_wr), .wb_dest(wb_dest), .wb_data(wb_data),
        .hist_wr(hist_wr_reg), .hist_dest(hist_dest_reg), .hist_data(hist_data_reg),
        .sel(sel_b), .data(d_b), .hazard(hz_b), .hazard_data(hzd_b[gi])
      );

      assign en_a           = br[gi] && (sel_a != SRC_RF);
      assign en_b           = br[gi] && (sel_b != SRC_RF);
      assign fwd_a_en_o[gi] = en_a;
      assign fwd_b_en_o[gi] = en_b;
      assign fwd_a_data[gi] = en_a ? d_a : '0;
      assign fwd_b_data[gi] = en_b ? d_b : '0;
      assign haz_a[gi]      = br[gi] && hz_a;
      assign haz_b[gi]      = br[gi] && hz_b;
    end
  endgenerate

  // Only the oldest hazard lane gets the latch; younger branches die on its resolution.
  always_comb begin
    hz_any   = 1'b0;
    cap_lane = '0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    cap_da   = '0;
    cap_db   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (haz_a[i] || haz_b[i]) begin
        hz_any   = 1'b1;
        cap_lane = LANE_IDX_W'(i);
        cap_a    = haz_a[i];
        cap_b    = haz_b[i];
        cap_da   = haz_a[i] ? hzd_a[i] : '0;
        cap_db   = haz_b[i] ? hzd_b[i] : '0;
      end
    end
  end

  assign stall_o = rst_n && !flush_i && (state_reg == IDLE) && hz_any;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hold_lane_reg <= '0;
      arm_a_reg     <= 1'b0;
      arm_b_reg     <= 1'b0;
      hold_a_reg    <= '0;
      hold_b_reg    <= '0;
    end else if (flush_i) begin
      state_reg  <= IDLE;
      arm_a_reg  <= 1'b0;
      arm_b_reg  <= 1'b0;
      hold_a_reg <= '0;
      hold_b_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hz_any) begin
            state_reg     <= HOLD;
            hold_lane_reg <= cap_lane;
            arm_a_reg     <= cap_a;
            arm_b_reg     <= cap_b;
            hold_a_reg    <= cap_da;
            hold_b_reg    <= cap_db;
          end
        end
        HOLD: begin
          state_reg <= IDLE;
          arm_a_reg <= 1'b0;
          arm_b_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_FWD_HIST_EN
  // Packet 0 is the youngest; idle WB cycles leave the history untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_wr_reg   <= '0;
      hist_dest_reg <= '0;
      hist_data_reg <= '0;
    end else if (|wb_valid_i) begin
      for (int p = HD - 1; p > 0; p--) begin
        hist_wr_reg[p]   <= hist_wr_reg[p-1];
        hist_dest_reg[p] <= hist_dest_reg[p-1];
        hist_data_reg[p] <= hist_data_reg[p-1];
      end
      hist_wr_reg[0]   <= wb_wr;
      hist_dest_reg[0] <= wb_dest;
      hist_data_reg[0] <= wb_data;
    end
  end
`else
  assign hist_wr_reg   = '0;
  assign hist_dest_reg = '0;
  assign hist_data_reg = '0;
`endif

endmodule

// File: tb/tb_branch_fwd_unit_nlane.sv
// Self-checking bench for branch_fwd_unit_nlane (LANES=2): directed scenarios then random traffic
// against a first-match-wins reference model; history expectations follow BRANCH_FWD_HIST_EN.
module tb_branch_fwd_unit_nlane;

  localparam int L  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int HD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [L-1:0] mv, mb, mr, ml, wv, wr;
  logic [L-1:0][RW-1:0] md, mrs, mrt, wd;
  logic [L-1:0][DW-1:0] malu, mrd, wdat;
  logic [L-1:0] fa_en, fb_en;
  logic [L-1:0][DW-1:0] fa_d, fb_d;
  logic stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_fwd_unit_nlane #(.LANES(L), .DATA_W(DW), .REG_W(RW), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .mem_valid_i(mv), .mem_branch_i(mb), .mem_regwr_i(mr), .mem_load_i(ml),
    .mem_dest_i(md), .mem_alu_i(malu), .mem_rdata_i(mrd),
    .mem_rs_i(mrs), .mem_rt_i(mrt),
    .wb_valid_i(wv), .wb_regwr_i(wr), .wb_dest_i(wd), .wb_data_i(wdat),
    .fwd_a_en_o(fa_en), .fwd_b_en_o(fb_en),
    .fwd_a_data_o(fa_d), .fwd_b_data_o(fb_d),
    .stall_o(stall)
  );

  // Reference model state
  typedef struct {
    bit            wr   [L];
    logic [RW-1:0] dest [L];
    logic [DW-1:0] data [L];
  } pkt_t;
  pkt_t hist[$];
  bit m_hold = 0, m_arm_a = 0, m_arm_b = 0;
  int m_lane = 0;
  logic [DW-1:0] m_da = '0, m_db = '0;
  bit c_any, c_a, c_b;
  int c_lane;
  logic [DW-1:0] c_da, c_db;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input int b, input logic [RW-1:0] src, input bit lon, input logic [DW-1:0] ld,
                         output bit en, output logic [DW-1:0] d, output bit haz, output logic [DW-1:0] hd);
    en = 0; d = '0; haz = 0; hd = '0;
    if (lon) begin en = 1; d = ld; return; end
    if (src == 0) return;
    for (int j = b - 1; j >= 0; j--)
      if (mv[j] && mr[j] && md[j] == src) begin
        if (ml[j]) begin haz = 1; hd = mrd[j]; end
        else begin en = 1; d = malu[j]; end
        return;
      end
    for (int j = L - 1; j >= 0; j--)
      if (wv[j] && wr[j] && wd[j] == src) begin en = 1; d = wdat[j]; return; end
`ifdef BRANCH_FWD_HIST_EN
    foreach (hist[p])
      for (int j = L - 1; j >= 0; j--)
        if (hist[p].wr[j] && hist[p].dest[j] == src) begin en = 1; d = hist[p].data[j]; return; end
`endif
  endtask

  task automatic settle_check();
    bit ha[L], hb[L], ea[L], eb[L];
    logic [DW-1:0] xa[L], xb[L], qa[L], qb[L];
    bit exp_stall, lon_a, lon_b;
    #1;
    c_any = 0; c_lane = 0; c_a = 0; c_b = 0; c_da = '0; c_db = '0;
    for (int b = 0; b < L; b++) begin
      ea[b] = 0; eb[b] = 0; xa[b] = '0; xb[b] = '0; ha[b] = 0; hb[b] = 0; qa[b] = '0; qb[b] = '0;
      if (mv[b] && mb[b]) begin
        lon_a = m_hold && m_lane == b && m_arm_a && rst_n && !flush;
        lon_b = m_hold && m_lane == b && m_arm_b && rst_n && !flush;
        resolve(b, mrs[b], lon_a, m_da, ea[b], xa[b], ha[b], qa[b]);
        resolve(b, mrt[b], lon_b, m_db, eb[b], xb[b], hb[b], qb[b]);
        if ((ha[b] || hb[b]) && !c_any) begin
          c_any = 1; c_lane = b; c_a = ha[b]; c_b = hb[b];
          c_da = ha[b] ? qa[b] : '0; c_db = hb[b] ? qb[b] : '0;
        end
      end
    end
    exp_stall = rst_n && !flush && !m_hold && c_any;
    check("stall", stall, exp_stall);
    for (int b = 0; b < L; b++) begin
      if (!(mv[b] && mb[b])) begin
        check($sformatf("nonbr_en_a[%0d]", b), fa_en[b], 0);
        check($sformatf("nonbr_en_b[%0d]", b), fb_en[b], 0);
        check($sformatf("nonbr_data_a[%0d]", b), fa_d[b], 0);
        check($sformatf("nonbr_data_b[%0d]", b), fb_d[b], 0);
      end else if (!exp_stall) begin
        if (!ha[b]) begin
          check($sformatf("en_a[%0d]", b), fa_en[b], ea[b]);
          check($sformatf("data_a[%0d]", b), fa_d[b], xa[b]);
        end
        if (!hb[b]) begin
          check($sformatf("en_b[%0d]", b), fb_en[b], eb[b]);
          check($sformatf("data_b[%0d]", b), fb_d[b], xb[b]);
        end
      end
    end
  endtask

  task automatic adv();
    if (!rst_n) begin
      m_hold = 0; m_arm_a = 0; m_arm_b = 0; m_da = '0; m_db = '0;
      hist.delete();
    end else begin
      if (flush || m_hold) begin
        m_hold = 0; m_arm_a = 0; m_arm_b = 0;
      end else if (c_any) begin
        m_hold = 1; m_lane = c_lane; m_arm_a = c_a; m_arm_b = c_b; m_da = c_da; m_db = c_db;
      end
      if (|wv) begin
        pkt_t p;
        for (int l = 0; l < L; l++) begin
          p.wr[l] = wv[l] && wr[l]; p.dest[l] = wd[l]; p.data[l] = wdat[l];
        end
        hist.push_front(p);
        if (hist.size() > HD) void'(hist.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush = 0; mv = '0; mb = '0; mr = '0; ml = '0; md = '0; malu = '0; mrd = '0;
    mrs = '0; mrt = '0; wv = '0; wr = '0; wd = '0; wdat = '0;
  endtask

  task automatic set_load_hazard(input logic [DW-1:0] rd);
    set_idle();
    mv = 2'b11; mr[0] = 1; ml[0] = 1; md[0] = 5'd9; mrd[0] = rd;
    mb[1] = 1; mrs[1] = 5'd9; mrt[1] = 5'd9;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset state
    settle_check();
    check("rst_stall", stall, 0);
    check("rst_en_a", fa_en, 0);
    adv();

    // Older MEM lane ALU result forwarded to branch in lane 1
    set_idle();
    mv = 2'b11; mr[0] = 1; md[0] = 5'd5; malu[0] = 32'h11; mb[1] = 1; mrs[1] = 5'd5;
    settle_check();
    check("mem_fwd_en", fa_en[1], 1);
    check("mem_fwd_data", fa_d[1], 32'h11);
    check("mem_fwd_stall", stall, 0);
    adv();

    // Two WB lanes write r7, younger lane wins
    set_idle();
    wv = 2'b11; wr = 2'b11; wd[0] = 5'd7; wd[1] = 5'd7; wdat[0] = 32'hA; wdat[1] = 32'hB;
    mv[0] = 1; mb[0] = 1; mrs[0] = 5'd7;
    settle_check();
    check("wb_young_data", fa_d[0], 32'hB);
    adv();

    // Load-use hazard: stall, then latched data in HOLD, then IDLE again
    set_load_hazard(32'h55);
    settle_check();
    check("ld_stall", stall, 1);
    adv();
    set_load_hazard(32'h66);
    settle_check();
    check("hold_stall", stall, 0);
    check("hold_data_a", fa_d[1], 32'h55);
    check("hold_data_b", fb_d[1], 32'h55);
    adv();
    settle_check();
    check("idle_again_stall", stall, 1);
    adv();
    set_idle();
    settle_check();
    adv();

    // Flush while in HOLD
    set_load_hazard(32'h21);
    settle_check();
    adv();
    set_load_hazard(32'h22);
    flush = 1;
    settle_check();
    check("flush_en_a", fa_en[1], 0);
    check("flush_en_b", fb_en[1], 0);
    check("flush_stall", stall, 0);
    adv();
    set_load_hazard(32'h23);
    settle_check();
    check("post_flush_stall", stall, 1);
    adv();

    // Reset while in HOLD
    rst_n = 0;
    settle_check();
    check("rst_hold_en_a", fa_en[1], 0);
    check("rst_hold_stall", stall, 0);
    adv();
    rst_n = 1;
    settle_check();
    check("post_rst_stall", stall, 1);
    adv();
    set_idle();
    settle_check();
    adv();

    // History: r3=1 then r3=2 retire, one idle cycle, then branch reads r3
    set_idle();
    wv[0] = 1; wr[0] = 1; wd[0] = 5'd3; wdat[0] = 32'h1;
    settle_check();
    adv();
    wdat[0] = 32'h2;
    settle_check();
    adv();
    set_idle();
    settle_check();
    adv();
    mv[0] = 1; mb[0] = 1; mrs[0] = 5'd3; mrt[0] = 5'd0;
    wv[1] = 1; wr[1] = 1; wd[1] = 5'd0; wdat[1] = 32'h77;
    settle_check();
`ifdef BRANCH_FWD_HIST_EN
    check("hist_en", fa_en[0], 1);
    check("hist_data", fa_d[0], 32'h2);
`else
    check("nohist_en", fa_en[0], 0);
    check("nohist_data", fa_d[0], 32'h0);
`endif
    check("r0_en", fb_en[0], 0);
    adv();

    // Random traffic with a small register range to force collisions
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int l = 0; l < L; l++) begin
        mv[l]   = ($urandom_range(0, 7) != 0);
        mb[l]   = $urandom_range(0, 1) != 0;
        mr[l]   = $urandom_range(0, 1) != 0;
        ml[l]   = ($urandom_range(0, 2) == 0);
        md[l]   = RW'($urandom_range(0, 3));
        mrs[l]  = RW'($urandom_range(0, 3));
        mrt[l]  = RW'($urandom_range(0, 3));
        malu[l] = $urandom;
        mrd[l]  = $urandom;
        wv[l]   = ($urandom_range(0, 2) != 0);
        wr[l]   = $urandom_range(0, 1) != 0;
        wd[l]   = RW'($urandom_range(0, 3));
        wdat[l] = $urandom;
      end
      settle_check();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
